// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: customer-side session FSM that assembles PIN/amount entries and drives the ATM core.
// Optional macro SESSION_TIMEOUT_EN enables an idle timeout in the entry states.
module atm_session_ctrl #(
    parameter int RSP_WAIT    = 4,
    parameter int AMT_DIGITS  = 6,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_in,
    input  logic [3:0]  card_acc,
    input  logic        card_lang,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        op_valid,
    input  logic [2:0]  op_sel,
    output logic [2:0]  operation,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic [15:0] newPin,
    output logic [31:0] amount,
    output logic        language,
    input  logic        success,
    input  logic [31:0] balance,
    output logic        busy,
    output logic        done,
    output logic        last_ok,
    output logic [31:0] last_bal,
    output logic        retained,
    output logic [3:0]  sess_state
);
    localparam int AW = $clog2(AMT_DIGITS + 1);
    localparam int WW = (RSP_WAIT > 2) ? $clog2(RSP_WAIT) : 1;
    localparam int FW = $clog2(MAX_TRIES + 1);
`ifdef SESSION_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_GET_PIN = 4'd1, S_GET_OP = 4'd2, S_GET_AMT = 4'd3, S_GET_NPIN = 4'd4,
        S_ISSUE = 4'd5, S_WAIT = 4'd6, S_RESULT = 4'd7, S_LOCKED = 4'd8
    } state_t;

    state_t          state_r, state_s;
    logic            card_d_r;
    logic [2:0]      op_r, op_s, operation_r;
    logic [15:0]     pin_r, pin_s, npin_r, npin_s;
    logic [2:0]      pin_cnt_r, pin_cnt_s, npin_cnt_r, npin_cnt_s;
    logic [31:0]     amt_r, amt_s, pin_acc_s, npin_acc_s, amt_acc_s, to_cnt_r;
    logic [AW-1:0]   amt_cnt_r, amt_cnt_s;
    logic [WW-1:0]   wait_cnt_r, wait_cnt_s;
    logic [FW-1:0]   fail_cnt_r, fail_cnt_s;
    logic [3:0]      acc_r, acc_s;
    logic            lang_r, lang_s, busy_r, done_r, last_ok_r, retained_r;
    logic [31:0]     last_bal_r;
    logic            sample_s, clear_s, digit_s, enter_s, cancel_s, entry_s, abort_s, to_hit_s;

    function automatic logic [31:0] dec_acc(input logic [31:0] v, input logic [3:0] d);
        return v * 32'd10 + {28'd0, d};
    endfunction

    assign digit_s    = key_valid && (key_code <= 4'd9);
    assign enter_s    = key_valid && (key_code == 4'd10);
    assign cancel_s   = key_valid && (key_code == 4'd11);
    assign pin_acc_s  = dec_acc({16'd0, pin_r}, key_code);
    assign npin_acc_s = dec_acc({16'd0, npin_r}, key_code);
    assign amt_acc_s  = dec_acc(amt_r, key_code);
    assign entry_s    = (state_r == S_GET_PIN) || (state_r == S_GET_OP) ||
                        (state_r == S_GET_AMT) || (state_r == S_GET_NPIN);
    assign to_hit_s   = TO_EN && entry_s && !(key_valid || op_valid) &&
                        (to_cnt_r == 32'(TIMEOUT_CYC - 1));
    // Card removal, CANCEL and timeout all end the session from an entry state.
    assign abort_s    = cancel_s || !card_in || to_hit_s;

    // Next-state and datapath next-value logic.
    always_comb begin
        state_s    = state_r;
        op_s       = op_r;
        pin_s      = pin_r;
        pin_cnt_s  = pin_cnt_r;
        npin_s     = npin_r;
        npin_cnt_s = npin_cnt_r;
        amt_s      = amt_r;
        amt_cnt_s  = amt_cnt_r;
        wait_cnt_s = wait_cnt_r;
        fail_cnt_s = fail_cnt_r;
        acc_s      = acc_r;
        lang_s     = lang_r;
        sample_s   = 1'b0;
        clear_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (card_in && !card_d_r) begin
                    acc_s   = card_acc;
                    lang_s  = card_lang;
                    clear_s = 1'b1;
                    state_s = S_GET_PIN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_GET_PIN: begin
                if (abort_s) begin
                    clear_s = 1'b1;
                    state_s = S_IDLE;
                end else if (digit_s && (pin_cnt_r < 3'd4)) begin
                    pin_s     = pin_acc_s[15:0];
                    pin_cnt_s = pin_cnt_r + 3'd1;
                end else if (enter_s && (pin_cnt_r == 3'd4)) begin
                    state_s = S_GET_OP;
                end else begin
                    state_s = S_GET_PIN;
                end
            end
            S_GET_OP: begin
                if (abort_s) begin
                    clear_s = 1'b1;
                    state_s = S_IDLE;
                end else if (op_valid && ((op_sel == 3'd4) || (op_sel == 3'd5))) begin
                    op_s      = op_sel;
                    amt_s     = 32'd0;
                    amt_cnt_s = '0;
                    state_s   = S_GET_AMT;
                end else if (op_valid && (op_sel == 3'd2)) begin
                    op_s       = op_sel;
                    npin_s     = 16'd0;
                    npin_cnt_s = 3'd0;
                    state_s    = S_GET_NPIN;
                end else if (op_valid && (op_sel == 3'd3)) begin
                    op_s    = op_sel;
                    state_s = S_ISSUE;
                end else begin
                    state_s = S_GET_OP;
                end
            end
            S_GET_AMT: begin
                if (abort_s) begin
                    clear_s = 1'b1;
                    state_s = S_IDLE;
                end else if (digit_s && (amt_cnt_r < AW'(AMT_DIGITS))) begin
                    amt_s     = amt_acc_s;
                    amt_cnt_s = amt_cnt_r + AW'(1);
                end else if (enter_s && (amt_cnt_r != '0)) begin
                    state_s = S_ISSUE;
                end else begin
                    state_s = S_GET_AMT;
                end
            end
            S_GET_NPIN: begin
                if (abort_s) begin
                    clear_s = 1'b1;
                    state_s = S_IDLE;
                end else if (digit_s && (npin_cnt_r < 3'd4)) begin
                    npin_s     = npin_acc_s[15:0];
                    npin_cnt_s = npin_cnt_r + 3'd1;
                end else if (enter_s && (npin_cnt_r == 3'd4)) begin
                    state_s = S_ISSUE;
                end else begin
                    state_s = S_GET_NPIN;
                end
            end
            S_ISSUE: begin
                wait_cnt_s = '0;
                if (RSP_WAIT <= 1) begin
                    sample_s = 1'b1;
                    state_s  = S_RESULT;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_r == WW'(RSP_WAIT - 2)) begin
                    sample_s = 1'b1;
                    state_s  = S_RESULT;
                end else begin
                    wait_cnt_s = wait_cnt_r + WW'(1);
                end
            end
            S_RESULT: begin
                if (last_ok_r) begin
                    fail_cnt_s = '0;
                    state_s    = card_in ? S_GET_OP : S_IDLE;
                end else if (fail_cnt_r == FW'(MAX_TRIES - 1)) begin
                    fail_cnt_s = fail_cnt_r + FW'(1);
                    state_s    = S_LOCKED;
                end else begin
                    fail_cnt_s = fail_cnt_r + FW'(1);
                    pin_s      = 16'd0;
                    pin_cnt_s  = 3'd0;
                    state_s    = card_in ? S_GET_PIN : S_IDLE;
                end
            end
            S_LOCKED: state_s = S_LOCKED;
            default:  state_s = S_IDLE;
        endcase
    end

    // State, datapath and registered core-interface outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            card_d_r    <= 1'b0;
            op_r        <= 3'd0;
            pin_r       <= 16'd0;
            pin_cnt_r   <= 3'd0;
            npin_r      <= 16'd0;
            npin_cnt_r  <= 3'd0;
            amt_r       <= 32'd0;
            amt_cnt_r   <= '0;
            wait_cnt_r  <= '0;
            fail_cnt_r  <= '0;
            acc_r       <= 4'd0;
            lang_r      <= 1'b0;
            operation_r <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            last_ok_r   <= 1'b0;
            last_bal_r  <= 32'd0;
            retained_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            card_d_r    <= card_in;
            op_r        <= op_s;
            pin_r       <= clear_s ? 16'd0 : pin_s;
            pin_cnt_r   <= clear_s ? 3'd0 : pin_cnt_s;
            npin_r      <= clear_s ? 16'd0 : npin_s;
            npin_cnt_r  <= clear_s ? 3'd0 : npin_cnt_s;
            amt_r       <= clear_s ? 32'd0 : amt_s;
            amt_cnt_r   <= clear_s ? '0 : amt_cnt_s;
            wait_cnt_r  <= wait_cnt_s;
            fail_cnt_r  <= fail_cnt_s;
            acc_r       <= acc_s;
            lang_r      <= lang_s;
            operation_r <= ((state_s == S_ISSUE) || (state_s == S_WAIT)) ? op_s : 3'd0;
            busy_r      <= (state_s == S_ISSUE) || (state_s == S_WAIT);
            done_r      <= sample_s;
            last_ok_r   <= sample_s ? success : last_ok_r;
            last_bal_r  <= sample_s ? balance : last_bal_r;
            retained_r  <= retained_r | (state_s == S_LOCKED);
        end
    end

    // Idle counter for the session timeout; held at zero outside entry states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_r <= 32'd0;
        end else if (!TO_EN || !entry_s || key_valid || op_valid || to_hit_s) begin
            to_cnt_r <= 32'd0;
        end else begin
            to_cnt_r <= to_cnt_r + 32'd1;
        end
    end

    assign operation  = operation_r;
    assign acc_num    = acc_r;
    assign pin        = pin_r;
    assign newPin     = npin_r;
    assign amount     = amt_r;
    assign language   = lang_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign last_ok    = last_ok_r;
    assign last_bal   = last_bal_r;
    assign retained   = retained_r;
    assign sess_state = state_r;
endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Customer-side front end that drives the ATM core's request interface. It collects card, keypad and menu input, and assembles the decimal PIN, amount and new-PIN entries into binary values. It then presents one transaction to the core, waits for the core's fixed response window, and captures the success and balance results. It also counts consecutive failures and retains the card after too many.

Parameters:
RSP_WAIT, 4, cycles the request is held on the core interface before the response is sampled (min 1)
AMT_DIGITS, 6, maximum decimal digits accepted for an amount
MAX_TRIES, 3, consecutive failed transactions before the card is retained
TIMEOUT_CYC, 1000, idle cycles before session abort (used only with SESSION_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
card_in  in  1  level; card present
card_acc  in  4  account number on card, sampled on card_in rise
card_lang  in  1  language preference, sampled on card_in rise
key_valid  in  1  one-cycle strobe for key_code
key_code  in  4  0-9 digit, 10 ENTER, 11 CANCEL, 12-15 ignored
op_valid  in  1  one-cycle menu strobe
op_sel  in  3  requested operation
operation  out  3  to core; 0 = no-op
acc_num  out  4  to core
pin  out  16  to core, binary value of the 4 entered digits
newPin  out  16  to core, binary value of the 4 entered digits
amount  out  32  to core, binary
language  out  1  to core
success  in  1  from core
balance  in  32  from core
busy  out  1  transaction in flight
done  out  1  one-cycle pulse when a result is captured
last_ok  out  1  captured success
last_bal  out  32  captured balance
retained  out  1  card retained; sticky until reset
sess_state  out  4  FSM state, for debug

Behaviour:
- Reset: all outputs are 0; FSM goes to IDLE; fail counter and digit accumulators clear. Reset may be asserted mid-transaction; the block aborts immediately and drives operation=0 from that point.
- Digit accumulation: value <= value*10 + digit, done in 32-bit arithmetic and truncated to the field width.
- PIN and newPin accept exactly 4 digits. Further digits are ignored. ENTER with fewer than 4 digits is ignored.
- Amount: extra digits beyond AMT_DIGITS are ignored. ENTER with zero digits is ignored.
- CANCEL in any entry state clears the accumulators and returns to IDLE.
- A card_in fall in any state other than LOCKED returns the FSM to IDLE after the current WAIT completes.
- Opcodes:
  - 3 balance: no extra entry.
  - 4 withdraw, 5 deposit: amount entry.
  - 2 change PIN: newPin entry.
  - 0, 1, 6, 7: op_valid is ignored.
- FSM:
  - IDLE: on a card_in rising edge, latch card_acc to acc_num and card_lang to language, then go to GET_PIN.
  - GET_PIN: on ENTER with 4 digits, go to GET_OP.
  - GET_OP: on op_valid with a legal opcode, go to GET_AMT, GET_NPIN or ISSUE as the opcode requires.
  - GET_AMT: on ENTER, go to ISSUE.
  - GET_NPIN: on ENTER, go to ISSUE.
  - ISSUE: drive operation=op for 1 cycle with busy=1, then go to WAIT.
  - WAIT: hold operation and operands for RSP_WAIT-1 further cycles (RSP_WAIT cycles total including ISSUE). On the last cycle, sample success and balance into last_ok and last_bal, and pulse done. Next state is RESULT.
  - RESULT: drive operation=0 and clear busy.
    - If last_ok=1: clear the fail counter and go to GET_OP (session continues).
    - Otherwise: increment the fail counter. If it reaches MAX_TRIES, go to LOCKED; else go to GET_PIN and clear pin.
  - LOCKED: retained=1, operation=0, all key and op input ignored; only reset leaves this state.
- Key and op strobes arriving during ISSUE, WAIT or RESULT are dropped.
- operation is 0 in every state except ISSUE and WAIT.

Optional Feature:
SESSION_TIMEOUT_EN:
- Defined: a counter resets on any key_valid or op_valid and counts in GET_PIN, GET_OP, GET_AMT and GET_NPIN. At TIMEOUT_CYC the FSM goes to IDLE and clears the accumulators. The fail counter is not incremented.
- Undefined: no timeout; entry states wait indefinitely.

Test Plan:
- Card rise with acc 1, keys 1,2,3,4,ENTER, op 3 -> operation=3, acc_num=1, pin=1234 held 4 cycles; done pulses once; last_bal=balance; then back in GET_OP.
- Same session, op 5, keys 1,0,0,0,ENTER -> amount=1000 and operation=5 for 4 cycles; with the core reporting success and balance 2000, last_ok=1 and last_bal=2000.
- PIN 9,9,9,9 with core success=0 three times -> fail count goes 1, 2, 3; after the 3rd, retained=1 and sess_state=LOCKED; later keys produce no operation.
- Keys 1,2,ENTER then 3,4,5,6,7,ENTER -> first ENTER ignored; pin=1234, fifth digit dropped.
- Reset asserted during WAIT -> operation, busy and retained all 0 immediately; FSM in IDLE.
- With SESSION_TIMEOUT_EN and TIMEOUT_CYC=20: idle 20 cycles in GET_OP -> FSM in IDLE; fail count unchanged.
